route_collector: RTL and testbench

ROUTE_COLLECTOR -- requirements
Module: route_collector

---
 rtl/route_collector.sv | 162 ++++++++++++++++
 tb/tb_route_collector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/route_collector.sv
// Lane-to-word router: two-stage pipeline with a safely reloaded source table and mode patterns.
// Optional build macro ROUTE_COLLECTOR_COLLISION_CHECK_EN enables duplicate-source detection.
package route_collector_pkg;

  typedef enum logic [2:0] {
    NORMAL       = 3'd0,
    ALL_SET_1    = 3'd1,
    ALL_SET_0    = 3'd2,
    MIDDLE_SET_1 = 3'd3,
    MIDDLE_SET_0 = 3'd4
  } mode_ctrl_t;

endpackage

module route_collector
  import route_collector_pkg::*;
#(
  parameter int unsigned N_LANES = 32,
  parameter int unsigned N_WORDS = 20,
  parameter int unsigned WORD_W  = 196
) (
  input  logic                              clk_390p625M,
  input  logic                              rst_n,
  input  logic [N_LANES:1][WORD_W-1:0]      data_lane,
  input  logic                              lane_valid,
  input  logic [N_WORDS:1][4:0]             word_source,
  input  mode_ctrl_t                        mode_ctrl,
  input  logic                              cfg_update_req,
  output logic                              cfg_update_ack,
  output logic [N_WORDS:1][WORD_W-1:0]      data_word,
  output logic                              word_valid,
  output logic                              collision_err,
  output logic [7:0]                        collision_cnt
);

  localparam int unsigned MID_POS  = 97;
  localparam logic [5:0]  LANE_MAX = 6'(N_LANES);
  localparam logic [WORD_W-1:0] MID_BIT = {{(WORD_W-1){1'b0}}, 1'b1} << MID_POS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   drain_cnt;
  logic   load_en;

  logic [N_WORDS:1][4:0]        src_act;
  logic [N_WORDS:1][WORD_W-1:0] lane_sel;
  logic [N_WORDS:1][WORD_W-1:0] s1_data;
  logic                         s1_valid;
  logic [N_WORDS:1][WORD_W-1:0] s2_nxt;

  // Update control: DRAIN blocks new beats for two cycles, LOAD swaps the table.
  always_ff @(posedge clk_390p625M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    case (state)
      IDLE:    if (cfg_update_req) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = LOAD;
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cfg_update_ack = load_en;

  always_ff @(posedge clk_390p625M or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 1; k <= N_WORDS; k++) src_act[k] <= 5'(k - 1);
    end else if (load_en) begin
      src_act <= word_source;
    end
  end

  // Stage 1: per-word lane select; codes beyond the lane count yield zero data.
  always_comb begin
    lane_sel = '0;
    for (int unsigned k = 1; k <= N_WORDS; k++) begin
      logic [5:0] idx;
      idx = {1'b0, src_act[k]} + 6'd1;
      if (idx <= LANE_MAX) lane_sel[k] = data_lane[idx];
    end
  end

  always_ff @(posedge clk_390p625M) begin
    s1_data <= lane_sel;
  end

  always_ff @(posedge clk_390p625M or negedge rst_n) begin
    if (!rst_n) s1_valid <= 1'b0;
    else        s1_valid <= lane_valid && (state == IDLE);
  end

  // Stage 2: mode is applied live, so a mode change affects the next registered word.
  always_comb begin
    s2_nxt = '0;
    for (int unsigned k = 1; k <= N_WORDS; k++) begin
      case (mode_ctrl)
        NORMAL:       s2_nxt[k] = s1_data[k];
        ALL_SET_1:    s2_nxt[k] = '1;
        ALL_SET_0:    s2_nxt[k] = '0;
        MIDDLE_SET_1: s2_nxt[k] = MID_BIT;
        MIDDLE_SET_0: s2_nxt[k] = ~MID_BIT;
        default:      s2_nxt[k] = '1;
      endcase
    end
  end

  always_ff @(posedge clk_390p625M or negedge rst_n) begin
    if (!rst_n) begin
      data_word  <= '0;
      word_valid <= 1'b0;
    end else begin
      data_word  <= s2_nxt;
      word_valid <= s1_valid;
    end
  end

`ifdef ROUTE_COLLECTOR_COLLISION_CHECK_EN
  logic coll_hit;

  // Checked against the incoming table so the flag reflects exactly what LOAD installs.
  always_comb begin
    coll_hit = 1'b0;
    for (int unsigned i = 1; i <= N_WORDS; i++) begin
      for (int unsigned j = i + 1; j <= N_WORDS; j++) begin
        if (word_source[i] == word_source[j]) coll_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_390p625M or negedge rst_n) begin
    if (!rst_n) begin
      collision_err <= 1'b0;
      collision_cnt <= '0;
    end else if (load_en) begin
      collision_err <= coll_hit;
      if (coll_hit && (collision_cnt != 8'hFF)) collision_cnt <= collision_cnt + 8'd1;
    end
  end
`else
  assign collision_err = 1'b0;
  assign collision_cnt = '0;
`endif

endmodule

// File: tb/tb_route_collector.sv
// Directed self-checking bench for route_collector: latency, table update, modes, collisions, reset abort.
module tb_route_collector;
  import route_collector_pkg::*;

  localparam int unsigned NL = 32;
  localparam int unsigned NW = 20;
  localparam int unsigned W  = 196;
`ifdef ROUTE_COLLECTOR_COLLISION_CHECK_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NL:1][W-1:0]     data_lane;
  logic                   lane_valid;
  logic [NW:1][4:0]       word_source;
  mode_ctrl_t             mode_ctrl;
  logic                   cfg_update_req;
  logic                   cfg_update_ack;
  logic [NW:1][W-1:0]     data_word;
  logic                   word_valid;
  logic                   collision_err;
  logic [7:0]             collision_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [W-1:0] mid;

  route_collector #(.N_LANES(NL), .N_WORDS(NW), .WORD_W(W)) dut (
    .clk_390p625M   (clk),
    .rst_n          (rst_n),
    .data_lane      (data_lane),
    .lane_valid     (lane_valid),
    .word_source    (word_source),
    .mode_ctrl      (mode_ctrl),
    .cfg_update_req (cfg_update_req),
    .cfg_update_ack (cfg_update_ack),
    .data_word      (data_word),
    .word_valid     (word_valid),
    .collision_err  (collision_err),
    .collision_cnt  (collision_cnt)
  );

  always #2 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] lane_word(input int unsigned n);
    logic [W-1:0] r;
    logic [7:0]   b;
    b = 8'(n);
    for (int unsigned i = 0; i < W; i++) r[i] = b[i % 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_update;
    logic got;
    cfg_update_req = 1'b1;
    tick();
    cfg_update_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (cfg_update_ack) got = 1'b1;
      else tick();
    end
    check("upd_ack_seen", got, 1);
    tick();
  endtask

  initial begin
    int unsigned acks, first_ack, second_ack;
    logic        seen;

    rst_n = 1'b1; lane_valid = 1'b0; cfg_update_req = 1'b0; mode_ctrl = NORMAL;
    mid = '0; mid[97] = 1'b1;
    for (int unsigned k = 1; k <= NL; k++) data_lane[k] = lane_word(k);
    for (int unsigned k = 1; k <= NW; k++) word_source[k] = 5'(k - 1);
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", word_valid, 0);
    check("rst_ack", cfg_update_ack, 0);
    check("rst_err", collision_err, 0);
    check("rst_cnt", collision_cnt, 0);
    check("rst_word1", data_word[1], '0);
    check("rst_word20", data_word[20], '0);
    tick(); tick();
    rst_n = 1'b1; lane_valid = 1'b1;

    // Two-cycle latency, identity routing after reset
    tick();
    check("lat1_valid", word_valid, 0);
    tick();
    check("lat2_valid", word_valid, 1);
    for (int unsigned k = 1; k <= NW; k++) check($sformatf("id_word%0d", k), data_word[k], lane_word(k));

    // Table update with reversed sources
    for (int unsigned k = 1; k <= NW; k++) word_source[k] = 5'(32 - k);
    cfg_update_req = 1'b1;
    tick();
    cfg_update_req = 1'b0;
    check("upd_c1_ack", cfg_update_ack, 0);
    tick();
    check("upd_c2_ack", cfg_update_ack, 0);
    check("upd_c2_valid", word_valid, 1);
    check("upd_c2_word1", data_word[1], lane_word(1));
    tick();
    check("upd_c3_ack", cfg_update_ack, 1);
    check("upd_c3_valid", word_valid, 0);
    tick();
    check("upd_c4_ack", cfg_update_ack, 0);
    check("upd_c4_valid", word_valid, 0);
    tick();
    check("upd_c5_valid", word_valid, 0);
    tick();
    check("upd_c6_valid", word_valid, 1);
    for (int unsigned k = 1; k <= NW; k++) check($sformatf("rev_word%0d", k), data_word[k], lane_word(33 - k));
    check("rev_err", collision_err, 0);

    // word_source changes without a LOAD must not reroute
    for (int unsigned k = 1; k <= NW; k++) word_source[k] = 5'd0;
    tick(); tick(); tick();
    check("hold_word1", data_word[1], lane_word(32));
    check("hold_word20", data_word[20], lane_word(13));

    // Mode sweep
    mode_ctrl = MIDDLE_SET_0; tick();
    check("m_mid0_w1", data_word[1], ~mid);
    check("m_mid0_w20", data_word[20], ~mid);
    check("m_mid0_valid", word_valid, 1);
    mode_ctrl = MIDDLE_SET_1; tick();
    check("m_mid1_w5", data_word[5], mid);
    mode_ctrl = ALL_SET_0; tick();
    check("m_all0_w7", data_word[7], '0);
    mode_ctrl = ALL_SET_1; tick();
    check("m_all1_w9", data_word[9], '1);
    mode_ctrl = mode_ctrl_t'(3'd7); tick();
    check("m_illegal_w1", data_word[1], '1);
    check("m_illegal_valid", word_valid, 1);
    mode_ctrl = NORMAL; tick();
    check("m_normal_w1", data_word[1], lane_word(32));

    // Held request gives back-to-back updates
    for (int unsigned k = 1; k <= NW; k++) word_source[k] = 5'(k - 1);
    cfg_update_req = 1'b1;
    acks = 0; first_ack = 0; second_ack = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      if (cfg_update_ack) begin
        acks++;
        if (acks == 1) first_ack = i;
        else begin
          second_ack = i;
          cfg_update_req = 1'b0;
        end
      end
    end
    cfg_update_req = 1'b0;
    check("b2b_acks", acks, 2);
    check("b2b_gap", second_ack - first_ack, 4);
    tick(); tick(); tick();
    check("b2b_word1", data_word[1], lane_word(1));

    // Collision detection and saturation
    word_source[1] = 5'd5; word_source[2] = 5'd5;
    do_update();
    check("col1_err", collision_err, COLL_EN);
    check("col1_cnt", collision_cnt, COLL_EN ? 1 : 0);
    tick(); tick();
    check("col_word1", data_word[1], lane_word(6));
    check("col_word2", data_word[2], lane_word(6));
    check("col_word3", data_word[3], lane_word(3));
    do_update();
    check("col2_cnt", collision_cnt, COLL_EN ? 2 : 0);
    for (int unsigned i = 0; i < 298; i++) do_update();
    check("col300_cnt", collision_cnt, COLL_EN ? 255 : 0);
    check("col300_err", collision_err, COLL_EN);
    word_source[1] = 5'd0; word_source[2] = 5'd1;
    do_update();
    check("clean_err", collision_err, 0);
    check("clean_cnt", collision_cnt, COLL_EN ? 255 : 0);

    // Reset during second DRAIN cycle aborts the update
    for (int unsigned k = 1; k <= NW; k++) word_source[k] = 5'(32 - k);
    cfg_update_req = 1'b1;
    tick();
    cfg_update_req = 1'b0;
    tick();
    check("abort_pre_ack", cfg_update_ack, 0);
    rst_n = 1'b0;
    #1;
    check("abort_rst_valid", word_valid, 0);
    check("abort_rst_ack", cfg_update_ack, 0);
    check("abort_rst_cnt", collision_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      if (cfg_update_ack) seen = 1'b1;
    end
    check("abort_no_ack", seen, 0);
    check("abort_valid", word_valid, 1);
    check("abort_word1", data_word[1], lane_word(1));
    check("abort_word20", data_word[20], lane_word(20));
    check("abort_cnt", collision_cnt, 0);
    check("abort_err", collision_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
